// File: rtl/hwpe_tcdm_flat_bridge_pkg.sv
// hwpe_tcdm_bridge_package: shared types, constants and parameter checks for the flat TCDM bridge
package hwpe_tcdm_bridge_package;

    localparam int TCDM_DW = 32;
    localparam int TCDM_AW = 32;
    localparam int OUTST_W = 4;

    typedef struct packed {
        logic [TCDM_AW-1:0]   add;
        logic                 wen;
        logic [TCDM_DW/8-1:0] be;
        logic [TCDM_DW-1:0]   data;
    } tcdm_req_t;

    function automatic bit params_ok(int mp, int dw, int buf_depth, int max_outst);
        return mp >= 1 && dw >= 8 && dw % 8 == 0 &&
               buf_depth >= 1 && buf_depth <= 4 &&
               max_outst >= 1 && max_outst <= (2 ** OUTST_W) - 1;
    endfunction

endpackage

// File: rtl/hwpe_tcdm_flat_bridge_if.sv
// hwpe_stream_intf_tcdm / hwpe_ctrl_intf_periph: accelerator-side TCDM and control buses
interface hwpe_stream_intf_tcdm #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic            req;
    logic            gnt;
    logic [AW-1:0]   add;
    logic            wen;
    logic [DW/8-1:0] be;
    logic [DW-1:0]   data;
    logic [DW-1:0]   r_data;
    logic            r_valid;

    modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
    modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

interface hwpe_ctrl_intf_periph #(
    parameter int ID_WIDTH = 10,
    parameter int DW       = 32,
    parameter int AW       = 32
);
    logic                req;
    logic                gnt;
    logic [AW-1:0]       add;
    logic                wen;
    logic [DW/8-1:0]     be;
    logic [DW-1:0]       data;
    logic [ID_WIDTH-1:0] id;
    logic [DW-1:0]       r_data;
    logic                r_valid;
    logic [ID_WIDTH-1:0] r_id;

    modport master (output req, add, wen, be, data, id, input gnt, r_data, r_valid, r_id);
    modport slave  (input req, add, wen, be, data, id, output gnt, r_data, r_valid, r_id);
endinterface

// File: rtl/hwpe_tcdm_flat_bridge_req_fifo.sv
// hwpe_tcdm_req_fifo: one TCDM port's request buffer, outstanding-transaction limiter and underflow flag
module hwpe_tcdm_req_fifo
    import hwpe_tcdm_bridge_package::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int BUF_DEPTH = 2,
    parameter int MAX_OUTST = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               in_req,
    output logic               in_gnt,
    input  logic [AW-1:0]      in_add,
    input  logic               in_wen,
    input  logic [DW/8-1:0]    in_be,
    input  logic [DW-1:0]      in_data,
    output logic               out_req,
    input  logic               out_gnt,
    output logic [AW-1:0]      out_add,
    output logic               out_wen,
    output logic [DW/8-1:0]    out_be,
    output logic [DW-1:0]      out_data,
    input  logic               r_valid_i,
    output logic [OUTST_W-1:0] outst_o,
    output logic               err_o
);

    localparam int PW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
    localparam logic [PW-1:0]      LAST  = PW'(BUF_DEPTH - 1);
    localparam logic [2:0]         DEPTH = 3'(BUF_DEPTH);
    localparam logic [OUTST_W-1:0] MAXO  = OUTST_W'(MAX_OUTST);

    typedef struct packed {
        logic [AW-1:0]   add;
        logic            wen;
        logic [DW/8-1:0] be;
        logic [DW-1:0]   data;
    } entry_t;

    entry_t [BUF_DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]          rd_q, rd_d, wr_q, wr_d;
    logic [2:0]             fill_q, fill_d;
    logic [OUTST_W-1:0]     cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   push, pop, under;

    // gnt only looks at occupancy at the start of the cycle, so a full FIFO stalls even if it pops
    assign in_gnt  = (fill_q != DEPTH) & ~clear_i;
    assign push    = in_req & in_gnt;
    assign out_req = (fill_q != 3'd0) & (cnt_q < MAXO);
    assign pop     = out_req & out_gnt;
    assign under   = r_valid_i & (cnt_q == '0);
    assign {out_add, out_wen, out_be, out_data} = mem_q[rd_q];
    assign outst_o = cnt_q;
    assign err_o   = err_q;

    // next buffer state; clear flushes entries but keeps the counter since responses still return
    always_comb begin
        mem_d  = mem_q;
        wr_d   = wr_q;
        rd_d   = pop ? (rd_q == LAST ? '0 : rd_q + 1'b1) : rd_q;
        fill_d = fill_q + 3'(push) - 3'(pop);
        if (push) begin
            mem_d[wr_q] = '{add: in_add, wen: in_wen, be: in_be, data: in_data};
            wr_d        = wr_q == LAST ? '0 : wr_q + 1'b1;
        end
        if (clear_i) begin
            rd_d   = '0;
            wr_d   = '0;
            fill_d = '0;
        end
        cnt_d = cnt_q + OUTST_W'(pop) - OUTST_W'(r_valid_i & ~under);
        err_d = ~clear_i & (err_q | under);
    end

    // buffer, pointers, outstanding counter and sticky error flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q  <= '0;
            rd_q   <= '0;
            wr_q   <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: rtl/hwpe_tcdm_flat_bridge.sv
// hwpe_tcdm_flat_bridge: binds HWPE TCDM/periph interfaces to flat cluster ports with buffering and limiting
module hwpe_tcdm_flat_bridge
    import hwpe_tcdm_bridge_package::*;
#(
    parameter int MP         = 3,
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int ID         = 10,
    parameter int BUF_DEPTH  = 2,
    parameter int MAX_OUTST  = 4,
    parameter int PERIPH_REG = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    hwpe_stream_intf_tcdm.slave          tcdm_s [MP],
    output logic [MP-1:0]                tcdm_req,
    output logic [MP-1:0]                tcdm_wen,
    output logic [MP-1:0][AW-1:0]        tcdm_add,
    output logic [MP-1:0][DW/8-1:0]      tcdm_be,
    output logic [MP-1:0][DW-1:0]        tcdm_data,
    input  logic [MP-1:0]                tcdm_gnt,
    input  logic [MP-1:0]                tcdm_r_valid,
    input  logic [MP-1:0][DW-1:0]        tcdm_r_data,
    input  logic                         periph_req,
    input  logic                         periph_wen,
    input  logic [AW-1:0]                periph_add,
    input  logic [DW/8-1:0]              periph_be,
    input  logic [DW-1:0]                periph_data,
    input  logic [ID-1:0]                periph_id,
    output logic                         periph_gnt,
    output logic                         periph_r_valid,
    output logic [DW-1:0]                periph_r_data,
    output logic [ID-1:0]                periph_r_id,
    hwpe_ctrl_intf_periph.master         periph_m,
    output logic [MP-1:0][OUTST_W-1:0]   outst_o,
    output logic [MP-1:0]                err_o
);

    if (!params_ok(MP, DW, BUF_DEPTH, MAX_OUTST)) begin : g_bad_params
        $error("hwpe_tcdm_flat_bridge: MP/DW/BUF_DEPTH/MAX_OUTST out of range");
    end

    for (genvar p = 0; p < MP; p++) begin : g_port
        hwpe_tcdm_req_fifo #(
            .DW        (DW),
            .AW        (AW),
            .BUF_DEPTH (BUF_DEPTH),
            .MAX_OUTST (MAX_OUTST)
        ) i_fifo (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .clear_i   (clear_i),
            .in_req    (tcdm_s[p].req),
            .in_gnt    (tcdm_s[p].gnt),
            .in_add    (tcdm_s[p].add),
            .in_wen    (tcdm_s[p].wen),
            .in_be     (tcdm_s[p].be),
            .in_data   (tcdm_s[p].data),
            .out_req   (tcdm_req[p]),
            .out_gnt   (tcdm_gnt[p]),
            .out_add   (tcdm_add[p]),
            .out_wen   (tcdm_wen[p]),
            .out_be    (tcdm_be[p]),
            .out_data  (tcdm_data[p]),
            .r_valid_i (tcdm_r_valid[p]),
            .outst_o   (outst_o[p]),
            .err_o     (err_o[p])
        );
        assign tcdm_s[p].r_valid = tcdm_r_valid[p];
        assign tcdm_s[p].r_data  = tcdm_r_data[p];
    end

    if (PERIPH_REG != 0) begin : g_periph_reg
        typedef struct packed {
            logic [AW-1:0]   add;
            logic            wen;
            logic [DW/8-1:0] be;
            logic [DW-1:0]   data;
            logic [ID-1:0]   id;
        } preq_t;

        preq_t         rq_q, rq_d;
        logic          rq_v_q, rq_v_d;
        logic          rs_v_q, rs_v_d;
        logic [DW-1:0] rs_data_q, rs_data_d;
        logic [ID-1:0] rs_id_q, rs_id_d;

        assign periph_gnt     = ~rq_v_q;
        assign periph_m.req   = rq_v_q;
        assign {periph_m.add, periph_m.wen, periph_m.be, periph_m.data, periph_m.id} = rq_q;
        assign periph_r_valid = rs_v_q;
        assign periph_r_data  = rs_data_q;
        assign periph_r_id    = rs_id_q;

        // hold one accepted request until the accelerator grants it; delay the response by one cycle
        always_comb begin
            rq_v_d    = rq_v_q ? ~periph_m.gnt : periph_req;
            rq_d      = rq_v_q ? rq_q : {periph_add, periph_wen, periph_be, periph_data, periph_id};
            rs_v_d    = periph_m.r_valid;
            rs_data_d = periph_m.r_data;
            rs_id_d   = periph_m.r_id;
        end

        // request and response slice registers
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rq_q      <= '0;
                rq_v_q    <= 1'b0;
                rs_v_q    <= 1'b0;
                rs_data_q <= '0;
                rs_id_q   <= '0;
            end else begin
                rq_q      <= rq_d;
                rq_v_q    <= rq_v_d;
                rs_v_q    <= rs_v_d;
                rs_data_q <= rs_data_d;
                rs_id_q   <= rs_id_d;
            end
        end
    end else begin : g_periph_comb
        assign periph_m.req   = periph_req;
        assign periph_m.add   = periph_add;
        assign periph_m.wen   = periph_wen;
        assign periph_m.be    = periph_be;
        assign periph_m.data  = periph_data;
        assign periph_m.id    = periph_id;
        assign periph_gnt     = periph_m.gnt;
        assign periph_r_valid = periph_m.r_valid;
        assign periph_r_data  = periph_m.r_data;
        assign periph_r_id    = periph_m.r_id;
    end

endmodule

// File: tb/tb_hwpe_tcdm_flat_bridge.sv
// tb_hwpe_tcdm_flat_bridge: randomized bench against a queue-based model of the bridge
module tb_hwpe_tcdm_flat_bridge;
    import hwpe_tcdm_bridge_package::*;

    localparam int MP = 3;
    localparam int DW = TCDM_DW;
    localparam int AW = TCDM_AW;
    localparam int ID = 10;
    localparam int BD = 2;
    localparam int MO = 4;

    logic clk     = 1'b0;
    logic rst_ni  = 1'b0;
    logic clear_i = 1'b0;
    always #5 clk = ~clk;

    hwpe_stream_intf_tcdm #(.DW(DW), .AW(AW)) tcdm_s [MP] ();
    hwpe_ctrl_intf_periph #(.ID_WIDTH(ID), .DW(DW), .AW(AW)) periph_m ();

    logic [MP-1:0]               s_req, s_gnt, s_rv;
    tcdm_req_t                   s_in [MP];
    logic [DW-1:0]               s_rdata [MP];
    logic [MP-1:0]               tcdm_req, tcdm_wen, tcdm_gnt, tcdm_r_valid, err_o;
    logic [MP-1:0][AW-1:0]       tcdm_add;
    logic [MP-1:0][DW/8-1:0]     tcdm_be;
    logic [MP-1:0][DW-1:0]       tcdm_data, tcdm_r_data;
    logic [MP-1:0][OUTST_W-1:0]  outst_o;
    logic                        periph_req, periph_wen, periph_gnt, periph_r_valid;
    logic [AW-1:0]               periph_add;
    logic [DW/8-1:0]             periph_be;
    logic [DW-1:0]               periph_data, periph_r_data;
    logic [ID-1:0]               periph_id, periph_r_id;
    logic                        m_gnt, m_rv;
    logic [DW-1:0]               m_rdata;
    logic [ID-1:0]               m_rid;

    for (genvar g = 0; g < MP; g++) begin : g_s
        assign tcdm_s[g].req  = s_req[g];
        assign tcdm_s[g].add  = s_in[g].add;
        assign tcdm_s[g].wen  = s_in[g].wen;
        assign tcdm_s[g].be   = s_in[g].be;
        assign tcdm_s[g].data = s_in[g].data;
        assign s_gnt[g]   = tcdm_s[g].gnt;
        assign s_rv[g]    = tcdm_s[g].r_valid;
        assign s_rdata[g] = tcdm_s[g].r_data;
    end
    assign periph_m.gnt     = m_gnt;
    assign periph_m.r_valid = m_rv;
    assign periph_m.r_data  = m_rdata;
    assign periph_m.r_id    = m_rid;

    hwpe_tcdm_flat_bridge #(
        .MP(MP), .DW(DW), .AW(AW), .ID(ID), .BUF_DEPTH(BD), .MAX_OUTST(MO), .PERIPH_REG(1)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .clear_i        (clear_i),
        .tcdm_s         (tcdm_s),
        .tcdm_req       (tcdm_req),
        .tcdm_wen       (tcdm_wen),
        .tcdm_add       (tcdm_add),
        .tcdm_be        (tcdm_be),
        .tcdm_data      (tcdm_data),
        .tcdm_gnt       (tcdm_gnt),
        .tcdm_r_valid   (tcdm_r_valid),
        .tcdm_r_data    (tcdm_r_data),
        .periph_req     (periph_req),
        .periph_wen     (periph_wen),
        .periph_add     (periph_add),
        .periph_be      (periph_be),
        .periph_data    (periph_data),
        .periph_id      (periph_id),
        .periph_gnt     (periph_gnt),
        .periph_r_valid (periph_r_valid),
        .periph_r_data  (periph_r_data),
        .periph_r_id    (periph_r_id),
        .periph_m       (periph_m),
        .outst_o        (outst_o),
        .err_o          (err_o)
    );

    // reference model: pending requests per port, outstanding counts, error flags, periph slot
    tcdm_req_t     mq [MP][$];
    int            mo [MP];
    bit            me [MP];
    bit            pv;
    logic [AW-1:0] pa;
    logic          pw;
    logic [3:0]    pb;
    logic [DW-1:0] pd;
    logic [ID-1:0] pi;
    bit            rv_m;
    logic [DW-1:0] rd_m;
    logic [ID-1:0] ri_m;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            hs_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < MP; p++) begin
            mq[p].delete();
            mo[p] = 0;
            me[p] = 0;
        end
        pv   = 0;
        rv_m = 0;
        rd_m = '0;
        ri_m = '0;
    endtask

    task automatic quiet();
        clear_i      = 1'b0;
        s_req        = '0;
        tcdm_gnt     = '0;
        tcdm_r_valid = '0;
        tcdm_r_data  = '0;
        for (int p = 0; p < MP; p++) s_in[p] = '0;
        periph_req  = 1'b0;
        periph_wen  = 1'b0;
        periph_add  = '0;
        periph_be   = '0;
        periph_data = '0;
        periph_id   = '0;
        m_gnt   = 1'b0;
        m_rv    = 1'b0;
        m_rdata = '0;
        m_rid   = '0;
    endtask

    // modes: 0 random, 1 backpressure, 2 limiter burst, 3 drain, 4 spurious response on port 1, 5 clear
    task automatic drive(input int mode);
        logic [31:0] r;
        clear_i = mode == 5 || (mode == 0 && $urandom_range(0, 63) == 0);
        for (int p = 0; p < MP; p++) begin
            r = $urandom;
            s_req[p]       = (mode == 1 || mode == 2) ? 1'b1 : (mode == 0 ? ($urandom_range(0, 2) != 0) : 1'b0);
            s_in[p].add    = $urandom;
            s_in[p].wen    = r[4];
            s_in[p].be     = r[3:0];
            s_in[p].data   = $urandom;
            tcdm_gnt[p]    = mode == 1 || mode == 4 || mode == 5 ? 1'b0 : (mode == 0 ? ($urandom_range(0, 3) != 0) : 1'b1);
            tcdm_r_valid[p] = mode == 0 ? (mo[p] > 0 ? r[8] : (!clear_i && $urandom_range(0, 31) == 0)) :
                              mode == 3 ? (mo[p] > 0) : (mode == 4 && p == 1);
            tcdm_r_data[p] = $urandom;
        end
        r = $urandom;
        periph_req  = r[0];
        periph_wen  = r[1];
        periph_be   = r[7:4];
        periph_id   = r[17:8];
        periph_add  = $urandom;
        periph_data = $urandom;
        m_gnt   = $urandom_range(0, 2) != 0;
        m_rv    = r[20];
        m_rdata = $urandom;
        m_rid   = r[31:22];
    endtask

    task automatic check_outputs();
        bit er;
        for (int p = 0; p < MP; p++) begin
            er = mq[p].size() > 0 && mo[p] < MO;
            chk($sformatf("s_gnt[%0d]", p), s_gnt[p], !clear_i && mq[p].size() < BD);
            chk($sformatf("tcdm_req[%0d]", p), tcdm_req[p], er);
            if (mq[p].size() > 0) begin
                chk($sformatf("tcdm_add[%0d]", p), tcdm_add[p], mq[p][0].add);
                chk($sformatf("tcdm_wen[%0d]", p), tcdm_wen[p], mq[p][0].wen);
                chk($sformatf("tcdm_be[%0d]", p), tcdm_be[p], mq[p][0].be);
                chk($sformatf("tcdm_data[%0d]", p), tcdm_data[p], mq[p][0].data);
            end
            chk($sformatf("s_r_valid[%0d]", p), s_rv[p], tcdm_r_valid[p]);
            chk($sformatf("s_r_data[%0d]", p), s_rdata[p], tcdm_r_data[p]);
            chk($sformatf("outst[%0d]", p), outst_o[p], mo[p]);
            chk($sformatf("err[%0d]", p), err_o[p], me[p]);
        end
        chk("periph_gnt", periph_gnt, !pv);
        chk("periph_m.req", periph_m.req, pv);
        if (pv) begin
            chk("periph_m.add", periph_m.add, pa);
            chk("periph_m.wen", periph_m.wen, pw);
            chk("periph_m.be", periph_m.be, pb);
            chk("periph_m.data", periph_m.data, pd);
            chk("periph_m.id", periph_m.id, pi);
        end
        chk("periph_r_valid", periph_r_valid, rv_m);
        chk("periph_r_data", periph_r_data, rd_m);
        chk("periph_r_id", periph_r_id, ri_m);
    endtask

    task automatic update();
        bit hs, push, under;
        for (int p = 0; p < MP; p++) begin
            hs    = mq[p].size() > 0 && mo[p] < MO && tcdm_gnt[p];
            push  = s_req[p] && !clear_i && mq[p].size() < BD;
            under = tcdm_r_valid[p] && mo[p] == 0;
            if (p == 0 && tcdm_req[0] && tcdm_gnt[0]) hs_cnt++;
            if (hs) void'(mq[p].pop_front());
            if (push) mq[p].push_back(s_in[p]);
            if (clear_i) mq[p].delete();
            mo[p] = mo[p] + int'(hs) - int'(tcdm_r_valid[p] && !under);
            me[p] = clear_i ? 1'b0 : (me[p] | under);
        end
        if (pv) begin
            if (m_gnt) pv = 0;
        end else if (periph_req) begin
            pv = 1;
            pa = periph_add;
            pw = periph_wen;
            pb = periph_be;
            pd = periph_data;
            pi = periph_id;
        end
        rv_m = m_rv;
        rd_m = m_rdata;
        ri_m = m_rid;
    endtask

    task automatic step(input int mode);
        @(negedge clk);
        drive(mode);
        #1;
        check_outputs();
        update();
    endtask

    task automatic check_reset_values(input string tag);
        for (int p = 0; p < MP; p++) begin
            chk($sformatf("%s tcdm_req[%0d]", tag, p), tcdm_req[p], 0);
            chk($sformatf("%s tcdm_add[%0d]", tag, p), tcdm_add[p], 0);
            chk($sformatf("%s tcdm_wen[%0d]", tag, p), tcdm_wen[p], 0);
            chk($sformatf("%s tcdm_be[%0d]", tag, p), tcdm_be[p], 0);
            chk($sformatf("%s tcdm_data[%0d]", tag, p), tcdm_data[p], 0);
            chk($sformatf("%s outst[%0d]", tag, p), outst_o[p], 0);
            chk($sformatf("%s err[%0d]", tag, p), err_o[p], 0);
        end
        chk({tag, " periph_gnt"}, periph_gnt, 1);
        chk({tag, " periph_m.req"}, periph_m.req, 0);
        chk({tag, " periph_r_valid"}, periph_r_valid, 0);
        chk({tag, " periph_r_data"}, periph_r_data, 0);
        chk({tag, " periph_r_id"}, periph_r_id, 0);
    endtask

    initial begin
        quiet();
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_ni = 1'b1;
        repeat (7) step(1);
        repeat (12) step(3);
        hs_cnt = 0;
        repeat (8) step(2);
        chk("limiter handshakes", hs_cnt, MO);
        repeat (12) step(3);
        repeat (2) step(4);
        chk("underflow err[1]", err_o[1], 1);
        chk("underflow outst[1]", outst_o[1], 0);
        step(5);
        repeat (2) step(3);
        chk("cleared err[1]", err_o[1], 0);
        repeat (2000) step(0);
        repeat (12) step(3);
        repeat (4) step(2);
        @(negedge clk);
        quiet();
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_values("async");
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (500) step(0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
